// File: rtl/stream_rx_ctrl.sv
// rtl/stream_rx_ctrl.sv - S_AXIS instruction loader: writes one stream into instruction memory, starts cores, waits for all to finish
module stream_rx_ctrl #(
    parameter int CORENUM = 16,
    parameter int DW      = 32,
    parameter int AW      = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               src_valid,
    input  logic [DW-1:0]      src_data,
    input  logic               src_last,
    output logic               src_ready,
    output logic               inst_we,
    output logic [AW-1:0]      inst_addr,
    output logic [DW-1:0]      inst_data,
    output logic [AW:0]        inst_len,
    output logic               run,
    output logic               busy,
    input  logic [CORENUM-1:0] core_last,
    output logic               done,
    output logic               overflow
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_DRAIN = 3'd2,
        S_START = 3'd3,
        S_WAIT  = 3'd4
    } state_t;

    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

    state_t             state, state_nxt;
    logic [AW:0]        cnt;
    logic [CORENUM-1:0] seen;
    logic               accept;
    logic               mem_full;
    logic               all_done;

    assign accept   = src_valid & src_ready;
    // cnt[AW] set means all 2**AW words are already stored
    assign mem_full = cnt[AW];
    assign all_done = &(seen | core_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = src_last ? S_START : S_LOAD;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    if (!mem_full) begin
                        state_nxt = src_last ? S_START : S_LOAD;
                    end else begin
                        state_nxt = src_last ? S_IDLE : S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (accept && src_last) begin
                    state_nxt = S_IDLE;
                end
            end
            S_START: state_nxt = S_WAIT;
            S_WAIT: begin
                if (all_done) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        src_ready = 1'b0;
        busy      = 1'b0;
        case (state)
            S_IDLE, S_LOAD, S_DRAIN: src_ready = !rst;
            S_START, S_WAIT:         busy      = 1'b1;
            default: begin
                src_ready = 1'b0;
                busy      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            inst_we   <= 1'b0;
            inst_addr <= '0;
            inst_data <= '0;
            inst_len  <= '0;
            run       <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            seen      <= '0;
        end else begin
            inst_we <= 1'b0;
            run     <= (state == S_START);
            done    <= (state == S_WAIT) && all_done;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        inst_we   <= 1'b1;
                        inst_addr <= '0;
                        inst_data <= src_data;
                        cnt       <= CNT_ONE;
                        overflow  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        if (!mem_full) begin
                            inst_we   <= 1'b1;
                            inst_addr <= cnt[AW-1:0];
                            inst_data <= src_data;
                            cnt       <= cnt + CNT_ONE;
                        end else begin
                            overflow  <= 1'b1;
                        end
                    end
                end
                S_START: begin
                    inst_len <= cnt;
                    seen     <= '0;
                end
                S_WAIT: begin
                    seen <= seen | core_last;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
